// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller:
// state codes, opcode map, alu_op/pc_src/alu_src_b codes.
package ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_R   = 4'd7;
  localparam logic [3:0] S_WB_I   = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ANDI = 6'b000001;
  localparam logic [5:0] OP_ORI  = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b000100;
  localparam logic [5:0] OP_SW   = 6'b000101;
  localparam logic [5:0] OP_BEQ  = 6'b000110;
  localparam logic [5:0] OP_J    = 6'b000111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_LOGI = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  typedef struct packed {
    logic r;
    logic logi;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic bad;
  } op_class_t;

endpackage

// File: rtl/op_decoder.sv
// Opcode classifier and extender select.
// op: latched opcode; cls: one-hot class; ext_op: 1 = sign-extend.
import ctrl_pkg::*;

module op_decoder (
  input  logic [5:0] op,
  output op_class_t  cls,
  output logic       ext_op
);

  always_comb begin
    cls    = '0;
    ext_op = 1'b0;
    unique case (op)
      OP_R:    cls.r = 1'b1;
      OP_ANDI,
      OP_ORI:  cls.logi = 1'b1;
      OP_ADDI: begin
        cls.addi = 1'b1;
        ext_op   = 1'b1;
      end
      OP_LW: begin
        cls.lw = 1'b1;
        ext_op = 1'b1;
      end
      OP_SW: begin
        cls.sw = 1'b1;
        ext_op = 1'b1;
      end
      OP_BEQ: begin
        cls.beq = 1'b1;
        ext_op  = 1'b1;
      end
      OP_J:    cls.j = 1'b1;
      default: cls.bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory wait timeout.
// In: clk, reset, opcode, zero, mem_ready. Out: datapath strobes/selects, illegal, mem_err, state.
import ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ext_op,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  // run stays low from reset until the first edge after release,
  // so that edge opens the first FETCH instead of acting on it.
  logic          run;
  logic [3:0]    st;
  logic [3:0]    nxt;
  logic [5:0]    op_q;
  logic [CW-1:0] cnt;
  op_class_t     cls;
  logic          dec_ext;
  logic          wait_st;
  logic          stall;
  logic          tmo;

  op_decoder u_dec (
    .op     (op_q),
    .cls    (cls),
    .ext_op (dec_ext)
  );

  assign wait_st = (st == S_FETCH) || (st == S_MEM_RD)
                || (st == S_MEM_WR);
  assign stall   = run && wait_st && !mem_ready;
  assign tmo     = stall && (cnt == CW'(WAIT_MAX));
  assign state   = st;

  always_comb begin
    nxt = st;
    unique case (st)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          cls.r:    nxt = S_EXEC_R;
          cls.logi,
          cls.addi: nxt = S_EXEC_I;
          cls.lw,
          cls.sw:   nxt = S_ADDR;
          cls.beq:  nxt = S_BRANCH;
          cls.j:    nxt = S_JUMP;
          default:  nxt = S_FETCH;
        endcase
      end
      S_EXEC_R: nxt = S_WB_R;
      S_EXEC_I: nxt = S_WB_I;
      S_ADDR:   nxt = cls.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) nxt = S_WB_MEM;
      S_MEM_WR: if (mem_ready) nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
    if (tmo) nxt = S_FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run  <= 1'b0;
      st   <= S_FETCH;
      op_q <= '0;
      cnt  <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        st <= nxt;
        if (st == S_FETCH && mem_ready)
          op_q <= opcode;
        // A timeout in FETCH keeps the state, so clear on tmo too.
        if (stall && !tmo && nxt == st)
          cnt <= cnt + 1'b1;
        else
          cnt <= '0;
      end
    end
  end

  always_comb begin
    ext_op     = run && dec_ext;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    illegal    = 1'b0;
    mem_err    = tmo;
    if (run) begin
      unique case (st)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_BROFF;
          illegal   = cls.bad;
        end
        S_EXEC_R: alu_op = ALU_FUNC;
        S_EXEC_I: begin
          alu_src_b = SRCB_IMM;
          alu_op    = cls.logi ? ALU_LOGI : ALU_ADD;
        end
        S_ADDR:   alu_src_b = SRCB_IMM;
        S_MEM_RD: mem_read = 1'b1;
        S_MEM_WR: mem_write = !tmo;
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_WB_I:   reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_op   = ALU_SUB;
          pc_src   = PC_BR;
          pc_write = zero;
        end
        S_JUMP: begin
          pc_src   = PC_JMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Directed spec scenarios plus a random instruction stream vs a path model.
import ctrl_pkg::*;

module tb_multicycle_ctrl;

  localparam int WM = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ext_op;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal;
  logic       mem_err;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] cur_op;
  logic [5:0] fetch_op;

  multicycle_ctrl #(.WAIT_MAX(WM)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ext_op     (ext_op),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .mem_err    (mem_err),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_zero(input string tag);
    logic [19:0] obs;
    obs = {ext_op, pc_write, ir_write, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_b, alu_op,
           pc_src, illegal, mem_err, state};
    n_tests++;
    assert (obs === 20'h0) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected 00000", tag, obs);
    end
  endtask

  // One controller cycle: the model says which state we are in and
  // what the inputs are; expected outputs follow from the output rules.
  task automatic step(input logic [3:0] st, input logic mr,
                      input logic z, input logic tmo);
    logic [9:0] expv;
    logic [9:0] obsv;
    logic [1:0] exp_alu;
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    opcode    = (st == S_FETCH) ? fetch_op : 6'($urandom);
    #1;
    expv = {
      (st == S_FETCH && mr) || (st == S_BRANCH && z) || st == S_JUMP,
      st == S_FETCH && mr,
      st == S_FETCH || st == S_MEM_RD,
      st == S_MEM_WR && !tmo,
      st == S_WB_R || st == S_WB_I || st == S_WB_MEM,
      st == S_WB_R,
      st == S_WB_MEM,
      cur_op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ},
      st == S_DECODE && cur_op > OP_J,
      tmo};
    obsv = {pc_write, ir_write, mem_read, mem_write, reg_write,
            reg_dst, mem_to_reg, ext_op, illegal, mem_err};
    n_tests++;
    assert (state === st) else begin
      n_fail++;
      $error("FAIL state t=%0t: observed %0d expected %0d",
             $time, state, st);
    end
    n_tests++;
    assert (obsv === expv) else begin
      n_fail++;
      $error("FAIL outputs st=%0d op=%0h t=%0t: observed %b expected %b",
             st, cur_op, $time, obsv, expv);
    end
    if (st inside {S_EXEC_R, S_EXEC_I, S_ADDR, S_BRANCH}) begin
      exp_alu = (st == S_BRANCH) ? 2'b01 :
                (st == S_EXEC_R) ? 2'b10 :
                (st == S_EXEC_I && cur_op inside {OP_ANDI, OP_ORI})
                  ? 2'b11 : 2'b00;
      n_tests++;
      assert (alu_op === exp_alu) else begin
        n_fail++;
        $error("FAIL alu_op st=%0d: observed %b expected %b",
               st, alu_op, exp_alu);
      end
    end
    if (st == S_BRANCH || st == S_JUMP) begin
      n_tests++;
      assert (pc_src === ((st == S_BRANCH) ? 2'b01 : 2'b10)) else begin
        n_fail++;
        $error("FAIL pc_src st=%0d: observed %b", st, pc_src);
      end
    end
    if (st == S_FETCH && mr) cur_op = fetch_op;
  endtask

  task automatic step_any(input logic [3:0] st);
    step(st, rb(), rb(), 1'b0);
  endtask

  task automatic mem_phase(input logic [3:0] st, input int mw,
                           output logic to);
    int k;
    k  = (mw > WM) ? WM : mw;
    to = (mw > WM);
    for (int i = 0; i < k; i++) step(st, 1'b0, rb(), 1'b0);
    if (to) step(st, 1'b0, rb(), 1'b1);
    else    step(st, 1'b1, rb(), 1'b0);
  endtask

  // Path of one instruction by opcode class; fw/mw are wait cycles
  // in FETCH and in the memory state.
  task automatic run_instr(input logic [5:0] op, input int fw,
                           input int mw, input logic z);
    logic to;
    fetch_op = op;
    for (int i = 0; i < fw; i++) step(S_FETCH, 1'b0, rb(), 1'b0);
    step(S_FETCH, 1'b1, rb(), 1'b0);
    step_any(S_DECODE);
    case (op)
      OP_R: begin
        step_any(S_EXEC_R);
        step_any(S_WB_R);
      end
      OP_ANDI, OP_ORI, OP_ADDI: begin
        step_any(S_EXEC_I);
        step_any(S_WB_I);
      end
      OP_LW: begin
        step_any(S_ADDR);
        mem_phase(S_MEM_RD, mw, to);
        if (!to) step_any(S_WB_MEM);
      end
      OP_SW: begin
        step_any(S_ADDR);
        mem_phase(S_MEM_WR, mw, to);
      end
      OP_BEQ: step(S_BRANCH, rb(), z, 1'b0);
      OP_J:   step_any(S_JUMP);
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] op;
    int r;
    reset     = 1'b1;
    opcode    = 6'h3f;
    zero      = 1'b1;
    mem_ready = 1'b1;
    cur_op    = OP_R;
    fetch_op  = OP_R;
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("reset_release_pre_edge");

    run_instr(OP_ORI, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 1, 0, 1'b0);
    run_instr(6'h3f, 0, 0, 1'b0);
    run_instr(OP_SW, 0, WM + 1, 1'b0);
    run_instr(OP_LW, 0, WM, 1'b0);
    run_instr(OP_J, 2, 0, 1'b0);
    run_instr(OP_R, 0, 0, 1'b0);

    // Reset in the middle of a MEM_WR wait.
    fetch_op = OP_SW;
    step(S_FETCH, 1'b1, 1'b0, 1'b0);
    step_any(S_DECODE);
    step_any(S_ADDR);
    step(S_MEM_WR, 1'b0, 1'b0, 1'b0);
    step(S_MEM_WR, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_zero("reset_mid_memwr");
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_mid_held");
    @(negedge clk);
    reset = 1'b0;
    cur_op = OP_R;
    #1;
    check_zero("reset_mid_release");
    run_instr(OP_ADDI, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 8) ? 6'(r) : 6'($urandom_range(8, 63));
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 4), rb());
    end
    run_instr(OP_SW, 1, WM, 1'b1);
    run_instr(OP_ANDI, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
